// File: rtl/spectrum_line_buf_pkg.sv
// Shared widths, defaults and the write-request record for the spectrum line buffer.
// Also holds the |re|+|im| magnitude helper.
package spectrum_line_buf_pkg;

  localparam int LINE_CNT_W      = 7;
  localparam int MAG_W           = 17;
  localparam int LEN_W           = 16;
  localparam int LINES_DEF       = 128;
  localparam int FFT_N_DEF       = 256;
  localparam int SCALE_SHIFT_DEF = 2;
  localparam int MAX_LEN_DEF     = 479;

  typedef struct packed {
    logic                  en;
    logic [LINE_CNT_W-1:0] idx;
    logic [MAG_W-1:0]      mag;
  } wr_req_t;

  // 17-bit result so |-32768|+|-32768| = 65536 does not wrap
  function automatic logic [MAG_W-1:0] mag_l1(input logic [15:0] re, input logic [15:0] im);
    logic [MAG_W-1:0] a, b;
    a = {1'b0, (re[15] ? (~re + 16'd1) : re)};
    b = {1'b0, (im[15] ? (~im + 16'd1) : im)};
    return a + b;
  endfunction

endpackage

// File: rtl/spectrum_line_buf_if.sv
// FFT bin stream in, display line request/response out.
interface spectrum_line_buf_if;
  import spectrum_line_buf_pkg::*;

  logic                  fft_valid;
  logic                  fft_sop;
  logic                  fft_eop;
  logic signed [15:0]    fft_re;
  logic signed [15:0]    fft_im;
  logic                  data_req;
  logic                  wr_over;
  logic [LINE_CNT_W-1:0] line_cnt;
  logic [LEN_W-1:0]      line_length;
  logic                  frame_swap;

  modport master (
    output fft_valid, fft_sop, fft_eop, fft_re, fft_im, data_req, wr_over,
    input  line_cnt, line_length, frame_swap
  );

  modport slave (
    input  fft_valid, fft_sop, fft_eop, fft_re, fft_im, data_req, wr_over,
    output line_cnt, line_length, frame_swap
  );
endinterface

// File: rtl/spec_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
module spec_dpram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 17,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)    mem[wr_addr] <= wr_data;
    if (rd_en) rd_data      <= mem[rd_addr];
  end
endmodule

// File: rtl/spectrum_line_buf.sv
// Ping-pong frame buffer of FFT magnitudes feeding the LCD bar renderer.
// Banks swap only when line_cnt wraps with a complete frame pending, so bars never tear.
module spectrum_line_buf
  import spectrum_line_buf_pkg::*;
#(
  parameter int LINES       = LINES_DEF,
  parameter int FFT_N       = FFT_N_DEF,
  parameter int SCALE_SHIFT = SCALE_SHIFT_DEF,
  parameter int MAX_LEN     = MAX_LEN_DEF
) (
  input logic                lcd_clk,
  input logic                sys_rst_n,
  spectrum_line_buf_if.slave bus
);
  localparam int BIN_W     = $clog2(FFT_N);
  localparam int AW        = $clog2(2*LINES);
  localparam int RD_STAGES = 1;

  logic                  rd_bank, pend, shown, wr_active;
  logic [BIN_W-1:0]      bin_cnt, cur_bin;
  logic                  frame_go, wrap, swap;
  wr_req_t               wr_req;
  logic [RD_STAGES:1]    vld_pipe;
  logic                  shown_q;
  logic [MAG_W-1:0]      rd_q;
  logic [AW-1:0]         wr_addr, rd_addr;
  logic [LINE_CNT_W-1:0] line_cnt;
  logic [LEN_W-1:0]      line_length;
  logic                  frame_swap;

  function automatic logic [AW-1:0] bank_addr(input logic bank, input logic [LINE_CNT_W-1:0] idx);
    return bank ? AW'(LINES + int'(idx)) : AW'(idx);
  endfunction

  function automatic logic [LEN_W-1:0] sat_len(input logic [MAG_W-1:0] q);
    logic [MAG_W-1:0] sh;
    sh = q >> SCALE_SHIFT;
    return (int'(sh) > MAX_LEN) ? LEN_W'(MAX_LEN) : LEN_W'(sh);
  endfunction

  always_comb begin
    frame_go = bus.fft_valid & (bus.fft_sop | wr_active);
    cur_bin  = bus.fft_sop ? '0 : bin_cnt;
    wrap     = bus.wr_over & (int'(line_cnt) == LINES - 1);
    swap     = wrap & pend;
  end

  // Write bank is resolved at RAM-write time, so a bin landing on the swap edge
  // still goes to the bank that is not being displayed.
  assign wr_addr = bank_addr(~rd_bank, wr_req.idx);
  assign rd_addr = bank_addr(rd_bank, line_cnt);

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bin_cnt   <= '0;
      wr_active <= 1'b0;
      pend      <= 1'b0;
      wr_req    <= '0;
    end else begin
      wr_req.en  <= frame_go & (int'(cur_bin) < LINES);
      wr_req.idx <= LINE_CNT_W'(cur_bin);
      wr_req.mag <= mag_l1(bus.fft_re, bus.fft_im);
      if (frame_go) begin
        bin_cnt   <= (int'(cur_bin) == FFT_N - 1) ? cur_bin : cur_bin + BIN_W'(1);
        wr_active <= ~bus.fft_eop;
      end
      // sop drops any pending frame; eop marks the write bank complete
      if (frame_go & (bus.fft_sop | bus.fft_eop)) pend <= bus.fft_eop;
      else if (swap)                               pend <= 1'b0;
    end
  end

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      line_cnt   <= '0;
      rd_bank    <= 1'b0;
      shown      <= 1'b0;
      frame_swap <= 1'b0;
    end else begin
      frame_swap <= swap;
      if (bus.wr_over) line_cnt <= wrap ? '0 : line_cnt + LINE_CNT_W'(1);
      if (swap) begin
        rd_bank <= ~rd_bank;
        shown   <= 1'b1;
      end
    end
  end

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_pipe    <= '0;
      shown_q     <= 1'b0;
      line_length <= '0;
    end else begin
      vld_pipe[1] <= bus.data_req;
      if (bus.data_req) shown_q <= shown;
      if (vld_pipe[RD_STAGES]) line_length <= shown_q ? sat_len(rd_q) : '0;
    end
  end

  spec_dpram #(.DEPTH(2*LINES), .WIDTH(MAG_W)) u_ram (
    .clk     (lcd_clk),
    .we      (wr_req.en),
    .wr_addr (wr_addr),
    .wr_data (wr_req.mag),
    .rd_en   (bus.data_req),
    .rd_addr (rd_addr),
    .rd_data (rd_q)
  );

  assign bus.line_cnt    = line_cnt;
  assign bus.line_length = line_length;
  assign bus.frame_swap  = frame_swap;
endmodule

// File: doc/spectrum_line_buf.md
Name: spectrum_line_buf

Overview:
- Buffers one frame of FFT output and serves per-line spectrum lengths to the LCD bar-drawing stage.
- Sits between the FFT core (re/im stream, already in the lcd_clk domain) and the display stage.
- Converts each bin to a magnitude (|re|+|im|) and stores the bins in a ping-pong RAM.
- Answers display data_req with a scaled, saturated line_length.
- Owns line_cnt: advances on wr_over, wraps at the end of the frame, and swaps banks only at that wrap so bars never tear.

Parameters:
- LINES, 128, bars per frame (line_cnt is 7 bits; LINES must be ≤ 128).
- FFT_N, 256, bins per FFT frame; only bins 0..LINES-1 are stored.
- SCALE_SHIFT, 2, right shift applied to magnitude.
- MAX_LEN, 479, saturation limit for line_length (display row width − 1).

Ports:
- lcd_clk      in   1   clock, rising edge
- sys_rst_n    in   1   asynchronous active-low reset
- fft_valid    in   1   bin qualifier
- fft_sop      in   1   first bin of frame (with fft_valid)
- fft_eop      in   1   last bin of frame (with fft_valid)
- fft_re       in   16  signed real part
- fft_im       in   16  signed imaginary part
- data_req     in   1   one-cycle request for line line_cnt
- wr_over      in   1   one-cycle, line line_cnt drawn
- line_cnt     out  7   current bar index
- line_length  out  16  bar length for line_cnt
- frame_swap   out  1   one-cycle pulse when the display bank changes

Behaviour:
- Reset values: line_cnt=0, line_length=0, frame_swap=0. Internal: rd_bank=0, pend=0, shown=0, bin_cnt=0, wr_active=0.
- Magnitude stage (1 register): mag[16:0] = |re| + |im|, computed in 17-bit unsigned. |−32768| = 32768; the maximum sum is 65536 and must not wrap.
- Write side, bank wr_bank = ~rd_bank:
  - fft_valid & fft_sop: bin_cnt=0, wr_active=1, pend=0. A sop arriving mid-frame restarts the frame and discards the partial data.
  - fft_valid & wr_active: write mag at address bin_cnt when bin_cnt < LINES; bin_cnt increments.
  - Bins ≥ LINES are ignored.
  - fft_valid & fft_eop & wr_active: wr_active=0, pend=1. A frame without eop never sets pend.
  - bin_cnt saturates at FFT_N−1. A valid without a preceding sop is ignored.
- Read side:
  - data_req at cycle t: RAM address {rd_bank, line_cnt} is sampled at t, RAM q is available at t+1, and line_length is registered at t+2.
  - line_length = shown ? min(q >> SCALE_SHIFT, MAX_LEN) : 0.
  - line_length holds its value until the next data_req.
- Line counter:
  - wr_over with line_cnt < LINES−1: line_cnt increments.
  - wr_over with line_cnt == LINES−1: line_cnt=0. If pend is registered high: rd_bank toggles, pend=0, shown=1, and frame_swap pulses on the next cycle.
- Simultaneous events:
  - eop and wrap in the same cycle: no swap, because pend is set after the edge. The swap occurs at the following wrap.
  - data_req and wr_over in the same cycle: the read uses the pre-increment line_cnt.
  - sop while pend=1: pend clears and the newer frame overwrites wr_bank. The display always shows the latest complete frame.
- Reset mid-frame clears pend and wr_active. The partial frame is lost and shown=0 until a new swap.

Decomposition:
- Shared package:
  - LINE_CNT_W=7.
  - MAG_W=17.
  - Default LINES, FFT_N, MAX_LEN.
- Sub-module spec_dpram:
  - Simple dual-port: 1 write port, 1 registered read port.
  - Depth 2·LINES, width MAG_W.
  - Maps to M9K.

Test Plan:
1. Reset, then data_req pulses before any frame → line_length=0, line_cnt=0, frame_swap stays 0.
2. Frame with bin k: re=64k, im=−64k, eop at bin 255, then 128 wr_over pulses → frame_swap pulses once after the 128th. Then data_req at line_cnt=3 → line_length=96 at data_req+2.
3. Frame with re=32767, im=−32768 on every bin, then swap → line_length=479 (saturated); 17-bit sum=65535 with no wrap.
4. 300 wr_over pulses with no frame pending → line_cnt sequence 0..127, 0..127, 0..43, with no frame_swap. eop asserted in the same cycle as the wrap → swap deferred to the next wrap.
5. sop, 50 bins, new sop, full frame with eop → only the second frame is displayed. A frame lacking eop is never displayed.
6. sys_rst_n asserted mid-frame at bin 20, released, full frame, wrap → line_length reflects only the post-reset frame; outputs are 0 during reset.
